// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcodes, ALUOp / ALUControl encodings and immediate-format codes.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone; R-type and unknown ops get I.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: ALUOp plus instruction fields to a 3-bit ALUControl.
module alu_decoder
  import rv_mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_ctrl_o
);

  // Subtract on funct3=000 only for R-type (op5) with funct7[5]; addi never subtracts.
  always_comb begin
    alu_ctrl_o = ALUC_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALUC_ADD;
      ALUOP_SUB: alu_ctrl_o = ALUC_SUB;
      ALUOP_FUNC: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_ctrl_o = ALUC_SLT;
          3'b110:  alu_ctrl_o = ALUC_OR;
          3'b111:  alu_ctrl_o = ALUC_AND;
          default: alu_ctrl_o = ALUC_ADD;
        endcase
      end
      default: alu_ctrl_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM. The state register is the only storage;
// all outputs are decoded from the state, with the write strobes also
// qualified by memory ready, the branch flag and reset.
module multicycle_control_unit
  import rv_mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int SUPPORT_BNE = 1,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 InstrDone,
  output logic                 Illegal
);

  state_e     state_q, state_d;
  logic       rdy;
  logic       bne_sel;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl3;
  logic       pc_update, branch, ir_wr, mem_wr, reg_wr, done, illegal;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Without wait states every memory access completes in the cycle it is issued.
  assign rdy     = MemReady | (MEM_WAIT_EN == 0);
  assign bne_sel = (SUPPORT_BNE != 0) && (funct3 == 3'b001);

  // State register; reset returns to FETCH at once, mid-instruction or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic; unreachable encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD :
                            (Op == OP_SW) ? S_MEMWRITE : S_FETCH;
      S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state output decode; the default arm is FETCH so stray encodings fetch too.
  always_comb begin
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = ~op_legal(Op);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        done   = rdy;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNC;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNC;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_wr     = rdy;
        pc_update = rdy;
      end
    endcase
  end

  // Strobes are held low for as long as reset is asserted.
  assign IRWrite   = rst & ir_wr;
  assign MemWrite  = rst & mem_wr;
  assign RegWrite  = rst & reg_wr;
  assign InstrDone = rst & done;
  assign Illegal   = rst & illegal;
  assign PCWrite   = rst & (pc_update | (branch & (zero ^ bne_sel)));
  assign ImmSrc    = imm_src(Op);

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7b5_i (funct7[5]),
    .op5_i      (Op[5]),
    .alu_ctrl_o (alu_ctrl3)
  );

  assign ALUControl = ALUCTRL_W'(alu_ctrl3);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: one instance with default parameters and
// one with SUPPORT_BNE=0 / MEM_WAIT_EN=0, checked cycle by cycle against
// expected output vectors queued as each cycle of stimulus is applied.
module tb_multicycle_control_unit;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                 XR = 6, XI = 7, AWB = 8, BR = 9, J = 10;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BRO = 7'b1100011, JALO = 7'b1101111,
                         BAD = 7'b1111111;

  typedef struct { string tag; logic [18:0] v; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic zero, mr, mr2;
  bit   sel2;

  logic MemReq1, MemWrite1, AdrSrc1, IRWrite1, PCWrite1, RegWrite1, InstrDone1, Illegal1;
  logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1;
  logic [2:0] ALUControl1;
  logic MemReq2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, InstrDone2, Illegal2;
  logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
  logic [2:0] ALUControl2;
  logic [18:0] obs1, obs2;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .MemReady(mr), .MemReq(MemReq1), .MemWrite(MemWrite1), .AdrSrc(AdrSrc1),
    .IRWrite(IRWrite1), .PCWrite(PCWrite1), .RegWrite(RegWrite1), .ResultSrc(ResultSrc1),
    .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ImmSrc(ImmSrc1), .ALUControl(ALUControl1),
    .InstrDone(InstrDone1), .Illegal(Illegal1)
  );

  multicycle_control_unit #(.SUPPORT_BNE(0), .MEM_WAIT_EN(0)) dut2 (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .MemReady(mr2), .MemReq(MemReq2), .MemWrite(MemWrite2), .AdrSrc(AdrSrc2),
    .IRWrite(IRWrite2), .PCWrite(PCWrite2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2),
    .InstrDone(InstrDone2), .Illegal(Illegal2)
  );

  assign obs1 = {MemReq1, MemWrite1, AdrSrc1, IRWrite1, PCWrite1, RegWrite1, ResultSrc1,
                 ALUSrcA1, ALUSrcB1, ImmSrc1, ALUControl1, InstrDone1, Illegal1};
  assign obs2 = {MemReq2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, ResultSrc2,
                 ALUSrcA2, ALUSrcB2, ImmSrc2, ALUControl2, InstrDone2, Illegal2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_exp(input logic [1:0] aop, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    case (f3)
      3'b000:  return (op[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector of one state, written from the per-state output table.
  function automatic logic [18:0] expv(input int s, input bit rdy, input logic [6:0] op,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic z, input bit bne, input bit rst_on);
    logic memreq = 0, mw = 0, ad = 0, ir = 0, pcw = 0, rw = 0, dn = 0, ill = 0;
    logic [1:0] rs = 0, a = 0, b = 0, aop = 0, imm;
    bit legal;
    legal = (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BRO) || (op == JALO);
    imm = (op == SW) ? 2'b01 : (op == BRO) ? 2'b10 : (op == JALO) ? 2'b11 : 2'b00;
    case (s)
      F:   begin memreq = 1; b = 2; rs = 2; ir = rdy; pcw = rdy; end
      D:   begin a = 1; b = 1; ill = !legal; end
      MA:  begin a = 2; b = 1; end
      MR:  begin memreq = 1; ad = 1; end
      MWB: begin rs = 1; rw = 1; dn = 1; end
      MW:  begin memreq = 1; ad = 1; mw = 1; dn = rdy; end
      XR:  begin a = 2; aop = 2; end
      XI:  begin a = 2; b = 1; aop = 2; end
      AWB: begin rw = 1; dn = 1; end
      BR:  begin a = 2; aop = 1; dn = 1; pcw = z ^ (bne && f3 == 3'b001); end
      J:   begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    if (!rst_on) begin mw = 0; ir = 0; pcw = 0; rw = 0; dn = 0; ill = 0; end
    return {memreq, mw, ad, ir, pcw, rw, rs, a, b, imm, alu_exp(aop, op, f3, f7), dn, ill};
  endfunction

  // One clock of stimulus: drive MemReady, queue the expectation, compare at the
  // falling edge, and return just after the next rising edge.
  task automatic cyc(input int s, input bit rdy_drv, input string tag);
    exp_t e;
    bit rdy_eff;
    if (sel2) begin mr2 = $urandom_range(0, 1); rdy_eff = 1; end
    else      begin mr = rdy_drv; rdy_eff = rdy_drv; end
    e.tag = tag;
    e.v   = expv(s, rdy_eff, Op, funct3, funct7, zero, !sel2, 1'b1);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, sel2 ? obs2 : obs1, e.v);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input int wf, input int wm);
    Op = op; funct3 = f3; funct7 = f7; zero = z;
    for (int i = 0; i < wf; i++) cyc(F, 1'b0, {nm, "_fetch_wait"});
    cyc(F, 1'b1, {nm, "_fetch"});
    cyc(D, $urandom_range(0, 1), {nm, "_decode"});
    case (op)
      LW: begin
        cyc(MA, $urandom_range(0, 1), {nm, "_memadr"});
        for (int i = 0; i < wm; i++) cyc(MR, 1'b0, {nm, "_memread_wait"});
        cyc(MR, 1'b1, {nm, "_memread"});
        cyc(MWB, $urandom_range(0, 1), {nm, "_memwb"});
      end
      SW: begin
        cyc(MA, $urandom_range(0, 1), {nm, "_memadr"});
        for (int i = 0; i < wm; i++) cyc(MW, 1'b0, {nm, "_memwrite_wait"});
        cyc(MW, 1'b1, {nm, "_memwrite"});
      end
      RT: begin
        cyc(XR, $urandom_range(0, 1), {nm, "_execr"});
        cyc(AWB, $urandom_range(0, 1), {nm, "_aluwb"});
      end
      IT: begin
        cyc(XI, $urandom_range(0, 1), {nm, "_execi"});
        cyc(AWB, $urandom_range(0, 1), {nm, "_aluwb"});
      end
      BRO: cyc(BR, $urandom_range(0, 1), {nm, "_branch"});
      JALO: begin
        cyc(J, $urandom_range(0, 1), {nm, "_jal"});
        cyc(AWB, $urandom_range(0, 1), {nm, "_aluwb"});
      end
      default: ;
    endcase
  endtask

  // Assert reset just after a rising edge, check both instances, release after the next edge.
  task automatic reset_pulse(input string nm);
    rst = 1'b0;
    mr = 1'b1;
    mr2 = 1'b1;
    #2;
    check({nm, "_dut1"}, obs1, expv(F, 1'b1, Op, funct3, funct7, zero, 1'b1, 1'b0));
    check({nm, "_dut2"}, obs2, expv(F, 1'b1, Op, funct3, funct7, zero, 1'b0, 1'b0));
    check({nm, "_memwrite_low"}, {31'd0, MemWrite1}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0;
    mr = 1'b1; mr2 = 1'b1; sel2 = 0;
    @(posedge clk);
    #1;
    reset_pulse("reset");

    instr("add",  RT, 3'b000, 7'b0000000, 1'b0, 0, 0);
    instr("sub",  RT, 3'b000, 7'b0100000, 1'b1, 0, 0);
    instr("or",   RT, 3'b110, 7'b0000000, 1'b0, 1, 0);
    instr("and",  RT, 3'b111, 7'b0000000, 1'b0, 0, 0);
    instr("slti", IT, 3'b010, 7'b0000000, 1'b0, 0, 0);
    instr("addi", IT, 3'b000, 7'b0100000, 1'b0, 2, 0);
    instr("lw_w3", LW, 3'b010, 7'b0000000, 1'b0, 0, 3);
    instr("sw_w2", SW, 3'b010, 7'b0000000, 1'b0, 0, 2);
    instr("lw",   LW, 3'b010, 7'b0000000, 1'b0, 0, 0);
    instr("sw",   SW, 3'b010, 7'b0000000, 1'b0, 0, 0);
    instr("beq_t",  BRO, 3'b000, 7'b0000000, 1'b1, 0, 0);
    instr("beq_nt", BRO, 3'b000, 7'b0000000, 1'b0, 0, 0);
    instr("bne_nt", BRO, 3'b001, 7'b0000000, 1'b1, 0, 0);
    instr("bne_t",  BRO, 3'b001, 7'b0000000, 1'b0, 0, 0);
    instr("jal",  JALO, 3'b000, 7'b0000000, 1'b0, 0, 0);
    instr("illegal", BAD, 3'b000, 7'b0000000, 1'b0, 0, 0);
    instr("after_ill", RT, 3'b000, 7'b0000000, 1'b0, 0, 0);

    // Reset in the middle of a stalled store.
    Op = SW; funct3 = 3'b010; funct7 = 7'd0; zero = 1'b0;
    cyc(F, 1'b1, "rstsw_fetch");
    cyc(D, 1'b0, "rstsw_decode");
    cyc(MA, 1'b0, "rstsw_memadr");
    cyc(MW, 1'b0, "rstsw_memwrite_wait");
    reset_pulse("rst_mid_sw");
    instr("post_rst", RT, 3'b000, 7'b0100000, 1'b0, 0, 0);

    // Second instance: no bne, memory ready ignored.
    sel2 = 1;
    mr = 1'b0;
    reset_pulse("reset2");
    instr("nb_bne_z1", BRO, 3'b001, 7'b0000000, 1'b1, 0, 0);
    instr("nb_bne_z0", BRO, 3'b001, 7'b0000000, 1'b0, 0, 0);
    instr("nb_lw",  LW, 3'b010, 7'b0000000, 1'b0, 0, 0);
    instr("nb_sw",  SW, 3'b010, 7'b0000000, 1'b0, 0, 0);
    instr("nb_sub", RT, 3'b000, 7'b0100000, 1'b0, 0, 0);
    instr("nb_jal", JALO, 3'b000, 7'b0000000, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
